// File: rtl/opendap_ap_mux.sv
// DAP access-port multiplexer: steers upstream AP accesses to one of N_APS
// downstream channels, with absent-AP handling, timeout auto-abort and DAPABORT.
module opendap_ap_mux #(
    parameter int N_APS          = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMEOUT_W      = 16,
    parameter int ERR_ON_ABSENT  = 1
) (
    input  logic                  swclk,
    input  logic                  rst_n,
    input  logic [7:0]            ap_sel,
    input  logic [5:0]            ap_addr,
    input  logic [31:0]           ap_wdata,
    input  logic                  ap_wen,
    input  logic                  ap_ren,
    input  logic                  ap_abort,
    output logic [31:0]           ap_rdata,
    output logic                  ap_rdy,
    output logic                  ap_err,
    output logic [5:0]            dn_addr,
    output logic [31:0]           dn_wdata,
    output logic [N_APS-1:0]      dn_wen,
    output logic [N_APS-1:0]      dn_ren,
    output logic [N_APS-1:0]      dn_abort,
    input  logic [32*N_APS-1:0]   dn_rdata,
    input  logic [N_APS-1:0]      dn_rdy,
    input  logic [N_APS-1:0]      dn_err,
    output logic                  timeout_event
);

    localparam int SEL_W = (N_APS > 1) ? $clog2(N_APS) : 1;

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] BUSY        = 3'd1;
    localparam logic [2:0] ABSENT_RESP = 3'd2;
    localparam logic [2:0] TO_ABORT    = 3'd3;
    localparam logic [2:0] TO_RESP     = 3'd4;

    localparam logic [TIMEOUT_W-1:0] TO_LAST =
        TIMEOUT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic ABSENT_ERR = (ERR_ON_ABSENT != 0);

    logic [2:0]           state_q, state_d;
    logic [SEL_W-1:0]     cur_sel_q, cur_sel_d;
    logic                 zero_rdata_q, zero_rdata_d;
    logic [TIMEOUT_W-1:0] count_q, count_d;
    logic [31:0]          rdata_q, rdata_d;

    logic [31:0] ch_rdata [N_APS];
    logic        sel_valid;
    logic        sel_rdy;
    logic        sel_err;

    for (genvar i = 0; i < N_APS; i++) begin : g_ch
        assign ch_rdata[i] = dn_rdata[32*i +: 32];
    end

    assign dn_addr   = ap_addr;
    assign dn_wdata  = ap_wdata;
    assign sel_valid = ({24'd0, ap_sel} < 32'(N_APS));
    assign sel_rdy   = dn_rdy[cur_sel_q];
    assign sel_err   = dn_err[cur_sel_q];

    always_comb begin
        // NOTE: every output and next-state signal gets a default here so no path infers a latch.
        state_d       = state_q;
        cur_sel_d     = cur_sel_q;
        zero_rdata_d  = zero_rdata_q;
        count_d       = '0;
        rdata_d       = rdata_q;
        dn_wen        = '0;
        dn_ren        = '0;
        dn_abort      = '0;
        ap_rdy        = 1'b1;
        ap_err        = 1'b0;
        ap_rdata      = zero_rdata_q ? 32'd0 : rdata_q;
        timeout_event = 1'b0;

        case (state_q)
            IDLE: begin
                if ((ap_wen || ap_ren) && !ap_abort) begin
                    if (sel_valid) begin
                        dn_wen[ap_sel[SEL_W-1:0]] = ap_wen;
                        dn_ren[ap_sel[SEL_W-1:0]] = ap_ren;
                        cur_sel_d    = ap_sel[SEL_W-1:0];
                        zero_rdata_d = 1'b0;
                        state_d      = BUSY;
                    end else begin
                        zero_rdata_d = 1'b1;
                        state_d      = ABSENT_RESP;
                    end
                end
            end
            BUSY: begin
                // Response data passes through live while waiting, then is held.
                ap_rdy   = sel_rdy;
                ap_err   = sel_rdy && sel_err;
                ap_rdata = ch_rdata[cur_sel_q];
                if (sel_rdy) begin
                    rdata_d = ch_rdata[cur_sel_q];
                    state_d = IDLE;
                end else if (TIMEOUT_CYCLES != 0) begin
                    count_d = count_q + 1'b1;
                    if (count_q == TO_LAST) state_d = TO_ABORT;
                end
            end
            TO_ABORT: begin
                dn_abort[cur_sel_q] = 1'b1;
                ap_rdy       = 1'b0;
                zero_rdata_d = 1'b1;
                state_d      = TO_RESP;
            end
            TO_RESP: begin
                ap_err        = 1'b1;
                timeout_event = 1'b1;
                state_d       = IDLE;
            end
            ABSENT_RESP: begin
                ap_err  = ABSENT_ERR;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // DAPABORT overrides everything, including a coincident new access.
        if (ap_abort) begin
            dn_abort = '1;
            state_d  = IDLE;
            count_d  = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking ones would race other flops.
    always_ff @(posedge swclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cur_sel_q    <= '0;
            zero_rdata_q <= 1'b1;
            count_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cur_sel_q    <= cur_sel_d;
            zero_rdata_q <= zero_rdata_d;
            count_q      <= count_d;
            rdata_q      <= rdata_d;
        end
    end

endmodule
